// File: rtl/quad_emu_pkg.sv
// Shared constants, FSM state type and phase-advance helper for the quadrature encoder emulator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package quad_emu_pkg;

    // Quadrature phase codes, written as {A,B}
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    // Rotation direction: CW means A leads B
    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } emu_state_t;

    // One Gray-code step of the {A,B} phase in the requested direction
    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
        logic [1:0] nxt;
        nxt = ph;
        if (dir == DIR_CW) begin
            case (ph)
                PH_00:   nxt = PH_10;
                PH_10:   nxt = PH_11;
                PH_11:   nxt = PH_01;
                default: nxt = PH_00;
            endcase
        end else begin
            case (ph)
                PH_00:   nxt = PH_01;
                PH_01:   nxt = PH_11;
                PH_11:   nxt = PH_10;
                default: nxt = PH_00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable, self-reloading down-counter producing a periodic single-cycle tick.
// Latency: tick every DIV enabled cycles after load; PRE_TICK moves the tick one cycle earlier (at count 1).
// Backpressure: none; the counter only advances while en is high.
module step_timer #(
    parameter int DIV      = 4,
    parameter bit PRE_TICK = 1'b0
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int             W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   RELOAD = W'(DIV - 1);
    // PRE_TICK fires on the cycle before the count reaches zero so that a
    // registered consumer shows its update in the cycle the count reads zero.
    localparam logic [W-1:0]   TICK_AT = PRE_TICK ? W'(1) : '0;

    logic [W-1:0] cnt;

    // Count down while enabled; reload on explicit load or on reaching zero
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || (en && (cnt == '0))) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == TICK_AT);

endmodule

// File: rtl/quad_encoder_emulator.sv
// Plays step commands out as quadrature A/B edges and generates fixed-width push-button pulses.
// Latency: first edge STEP_DIV cycles after accept, then one edge per STEP_DIV cycles; done one cycle after the last edge.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored otherwise, so the source holds it until accepted.
module quad_encoder_emulator
    import quad_emu_pkg::*;
#(
    parameter int STEP_DIV = 100000,
    parameter int CNT_W    = 8,
    parameter int BTN_CYC  = 1000000
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             btn_req,
    output logic             A,
    output logic             B,
    output logic             BTN,
    output logic             busy,
    output logic             done
);

    emu_state_t       state;
    logic             dir_q;
    logic [CNT_W-1:0] rem;
    logic [1:0]       phase;
    logic             accept;
    logic             step_tick;
    logic             btn_start;
    logic             btn_tick;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready;

    // Edge-rate divider: loaded on accept, free-running only while a command plays
    step_timer #(
        .DIV      (STEP_DIV),
        .PRE_TICK (1'b1)
    ) u_step_timer (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .load       (accept),
        .en         (state == RUN),
        .tick       (step_tick)
    );

    // Command FSM; busy/done/cmd_ready are registered alongside the state.
    // cmd_ready only re-arms from inside IDLE, which leaves one settling cycle
    // after FIN before a new command can be taken.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir_q     <= DIR_CW;
            rem       <= '0;
            phase     <= PH_00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        dir_q     <= cmd_dir;
                        rem       <= cmd_steps;
                        if (cmd_steps != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (rem == '0) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (step_tick) begin
                        phase <= next_phase(phase, dir_q);
                        rem   <= rem - 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign A = phase[1];
    assign B = phase[0];

    // A press can only start while the button is released; requests during a press are dropped
    assign btn_start = btn_req && !BTN;

    // Press-width timer, counting only while the button is held
    step_timer #(
        .DIV      (BTN_CYC),
        .PRE_TICK (1'b0)
    ) u_btn_timer (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .load       (btn_start),
        .en         (BTN),
        .tick       (btn_tick)
    );

    // Button output: set on a new press, cleared when the press timer expires
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            BTN <= 1'b0;
        end else if (btn_start) begin
            BTN <= 1'b1;
        end else if (btn_tick) begin
            BTN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Scoreboard bench for quad_encoder_emulator: expected edges/done pulses are queued at command time and checked as they appear.
// Latency: n/a.
// Backpressure: commands are held until cmd_ready, bounded by a cycle budget.
module tb_quad_encoder_emulator;

    localparam int STEP_DIV = 4;
    localparam int CNT_W    = 8;
    localparam int BTN_CYC  = 6;

    logic             clk_100MHz = 1'b0;
    logic             rst_n      = 1'b0;
    logic             cmd_valid  = 1'b0;
    logic             cmd_dir    = 1'b0;
    logic [CNT_W-1:0] cmd_steps  = '0;
    logic             btn_req    = 1'b0;
    logic             cmd_ready;
    logic             A;
    logic             B;
    logic             BTN;
    logic             busy;
    logic             done;

    typedef struct {
        logic [1:0] ph;
        int         at;
    } exp_edge_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_edges = 0;
    exp_edge_t  edge_q[$];
    int         done_q[$];
    exp_edge_t  e_pop;
    int         d_pop;
    logic [1:0] prev_ph  = 2'b00;
    logic [1:0] model_ph = 2'b00;

    quad_encoder_emulator #(
        .STEP_DIV (STEP_DIV),
        .CNT_W    (CNT_W),
        .BTN_CYC  (BTN_CYC)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .btn_req    (btn_req),
        .A          (A),
        .B          (B),
        .BTN        (BTN),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference CW order 00,10,11,01; CCW walks the same table backwards
    function automatic logic [1:0] tb_next(input logic [1:0] ph, input logic dir);
        logic [1:0] seq [4];
        int idx;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        idx = 0;
        for (int i = 0; i < 4; i++) if (seq[i] == ph) idx = i;
        return dir ? seq[(idx + 1) % 4] : seq[(idx + 3) % 4];
    endfunction

    // Output monitor: pops the scoreboard on every A/B change and on every done pulse
    always @(negedge clk_100MHz) begin
        if (!rst_n) begin
            prev_ph = 2'b00;
        end else begin
            if ({A, B} !== prev_ph) begin
                n_edges++;
                if (edge_q.size() == 0) begin
                    check_val("edge_unexpected", {A, B}, prev_ph);
                end else begin
                    e_pop = edge_q.pop_front();
                    check_val("edge_phase", {A, B}, e_pop.ph);
                    check_val("edge_cycle", cyc, e_pop.at);
                end
                prev_ph = {A, B};
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check_val("done_unexpected", done, 0);
                end else begin
                    d_pop = done_q.pop_front();
                    check_val("done_cycle", cyc, d_pop);
                end
            end
        end
    end

    // Waits for cmd_ready, queues expectations, then holds valid for the accepting edge.
    // Returns at the negedge right after the accept edge (cyc == acc).
    task automatic send_cmd(input logic dir, input int steps, input logic with_btn, output int acc);
        int k;
        acc = -1;
        k = 0;
        while (k < 200 && cmd_ready !== 1'b1) begin
            @(negedge clk_100MHz);
            k++;
        end
        if (cmd_ready !== 1'b1) begin
            check_val("ready_timeout", cmd_ready, 1);
            return;
        end
        acc = cyc + 1;
        for (int i = 1; i <= steps; i++) begin
            model_ph = tb_next(model_ph, dir);
            edge_q.push_back('{model_ph, acc + i * STEP_DIV - 1});
        end
        done_q.push_back(acc + steps * STEP_DIV);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = steps[CNT_W-1:0];
        btn_req   = with_btn;
        @(negedge clk_100MHz);
        cmd_valid = 1'b0;
        btn_req   = 1'b0;
    endtask

    // Wait for the scoreboard to empty, bounded
    task automatic drain();
        int k;
        k = 0;
        while (k < 2000 && (edge_q.size() != 0 || done_q.size() != 0)) begin
            @(negedge clk_100MHz);
            k++;
        end
        check_val("drain_left", edge_q.size() + done_q.size(), 0);
        repeat (3) @(negedge clk_100MHz);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int e0;

        // Reset values
        repeat (3) @(negedge clk_100MHz);
        check_val("rst_ready", cmd_ready, 1);
        check_val("rst_ab", {A, B}, 2'b00);
        check_val("rst_btn", BTN, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_100MHz);

        // CW 4 steps with per-cycle busy / cmd_ready profile
        send_cmd(1'b1, 4, 1'b0, acc);
        for (int k = 0; k <= 18; k++) begin
            check_val($sformatf("cw4_busy_k%0d", k), busy, (k <= 15) ? 1 : 0);
            check_val($sformatf("cw4_ready_k%0d", k), cmd_ready, (k >= 18) ? 1 : 0);
            @(negedge clk_100MHz);
        end
        drain();
        check_val("cw4_end_phase", {A, B}, 2'b00);

        // CCW 3 then CW 1: phase carries across commands
        send_cmd(1'b0, 3, 1'b0, acc);
        drain();
        send_cmd(1'b1, 1, 1'b0, acc);
        drain();
        check_val("cont_end_phase", {A, B}, 2'b11);

        // Zero-step command: done only, ready low two cycles, no edge
        send_cmd(1'b1, 0, 1'b0, acc);
        check_val("zero_ready_k0", cmd_ready, 0);
        check_val("zero_busy_k0", busy, 0);
        @(negedge clk_100MHz);
        check_val("zero_ready_k1", cmd_ready, 0);
        check_val("zero_done_k1", done, 0);
        @(negedge clk_100MHz);
        check_val("zero_ready_k2", cmd_ready, 1);
        check_val("zero_phase", {A, B}, 2'b11);
        drain();

        // cmd_valid pulsed mid-run is ignored
        e0 = n_edges;
        send_cmd(1'b1, 5, 1'b0, acc);
        repeat (6) @(negedge clk_100MHz);
        check_val("run_ready_low", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_steps = 8'd2;
        @(negedge clk_100MHz);
        cmd_valid = 1'b0;
        drain();
        check_val("run_ignored_edges", n_edges - e0, 5);

        // Button: retrigger inside a press ignored, later request gives a fresh press
        btn_req = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk_100MHz);
            check_val($sformatf("btn_k%0d", k), BTN,
                      ((k >= 1 && k <= 6) || (k >= 11 && k <= 16)) ? 1 : 0);
            btn_req = (k == 3 || k == 10) ? 1'b1 : 1'b0;
        end
        btn_req = 1'b0;

        // Reset in the middle of a 10-step command with a press started on the accept cycle
        send_cmd(1'b1, 10, 1'b1, acc);
        check_val("both_btn", BTN, 1);
        check_val("both_busy", busy, 1);
        repeat (4) @(negedge clk_100MHz);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ab", {A, B}, 2'b00);
        check_val("mid_rst_btn", BTN, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_edges_left", edge_q.size(), 9);
        check_val("mid_rst_done_pending", done_q.size(), 1);
        edge_q.delete();
        done_q.delete();
        model_ph = 2'b00;
        repeat (3) @(negedge clk_100MHz);
        rst_n = 1'b1;
        @(negedge clk_100MHz);
        check_val("post_rst_ready", cmd_ready, 1);
        send_cmd(1'b1, 1, 1'b0, acc);
        drain();
        check_val("post_rst_phase", {A, B}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
